// File: rtl/udp_deadlock_pkg.sv
// Shared types and constants for the dataflow deadlock reporter.
// Beat count depends on the UDP_DEADLOCK_STALL_CNT_EN build option.
package udp_deadlock_pkg;

    typedef enum logic [1:0] {IDLE, CONFIRM, REPORT, HOLD} rpt_state_e;

    localparam logic [15:0] RPT_MAGIC = 16'hDEAD;
    localparam int unsigned RPT_W     = 32;

    function automatic int unsigned ninfo(int unsigned num_axis);
        return (4 * num_axis + RPT_W - 1) / RPT_W;
    endfunction

    function automatic int unsigned nbeats(int unsigned num_axis);
`ifdef UDP_DEADLOCK_STALL_CNT_EN
        return 3 + ninfo(num_axis);
`else
        return 2 + ninfo(num_axis);
`endif
    endfunction

endpackage

// File: rtl/udp_deadlock_confirm.sv
// Free-running timestamp plus persistence filter on the monitor's block flag.
// Pulses confirm_o once block has stayed high long enough; ts_first_o holds the rise time.
module udp_deadlock_confirm #(
    parameter int unsigned CONFIRM_CYCLES = 16,
    parameter int unsigned TS_WIDTH       = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                abort_i,
    input  logic                block_i,
    output logic                confirm_o,
    output logic [TS_WIDTH-1:0] ts_first_o
);

    localparam int unsigned CntW = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(CONFIRM_CYCLES);

    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] ts_first_q;
    logic [CntW-1:0]     cnt_q;
    logic [CntW-1:0]     cnt_d;
    logic                first_hit;

    assign first_hit  = enable_i && !abort_i && block_i && (cnt_q == '0);
    assign ts_first_o = ts_first_q;

    always_comb begin
        cnt_d     = cnt_q;
        confirm_o = 1'b0;
        if (!enable_i || abort_i || !block_i) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            // A single-cycle filter declares on the very first high sample
            if (CONFIRM_CYCLES == 1) begin
                confirm_o = 1'b1;
            end else begin
                cnt_d = CntW'(1);
            end
        end else if (cnt_q >= CntMax) begin
            confirm_o = 1'b1;
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q       <= '0;
            ts_first_q <= '0;
            cnt_q      <= '0;
        end else begin
            ts_q  <= ts_q + 1'b1;
            cnt_q <= cnt_d;
            if (first_hit) begin
                ts_first_q <= ts_q;
            end
        end
    end

endmodule

// File: rtl/udp_hls_deadlock_reporter.sv
// Confirms a persistent dataflow deadlock and emits one framed report on a valid/ready stream.
// Define UDP_DEADLOCK_STALL_CNT_EN to append a saturating stall-cycle count beat.
module udp_hls_deadlock_reporter
    import udp_deadlock_pkg::*;
#(
    parameter int unsigned NUM_AXIS       = 4,
    parameter int unsigned CONFIRM_CYCLES = 16,
    parameter int unsigned TS_WIDTH       = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  block_in,
    input  logic [4*NUM_AXIS-1:0] axis_block_info,
    input  logic                  clear,
    output logic                  rpt_valid,
    input  logic                  rpt_ready,
    output logic [31:0]           rpt_data,
    output logic                  rpt_last,
    output logic                  deadlock
);

    localparam int unsigned InfoW  = 4 * NUM_AXIS;
    localparam int unsigned NInfo  = ninfo(NUM_AXIS);
    localparam int unsigned NBeats = nbeats(NUM_AXIS);
    localparam int unsigned BeatW  = $clog2(NBeats + 1);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(NBeats - 1);

    rpt_state_e          state_q, state_d;
    logic [BeatW-1:0]    beat_q, beat_d;
    logic                deadlock_q, deadlock_d;
    logic [InfoW-1:0]    info_snap_q;
    logic [NInfo*RPT_W-1:0] info_pad;
    logic [BeatW-1:0]    info_idx;
    logic                confirm;
    logic [TS_WIDTH-1:0] ts_first;
    logic                accept;

    udp_deadlock_confirm #(
        .CONFIRM_CYCLES (CONFIRM_CYCLES),
        .TS_WIDTH       (TS_WIDTH)
    ) u_confirm (
        .clock      (clock),
        .reset      (reset),
        .enable_i   ((state_q == IDLE) || (state_q == CONFIRM)),
        .abort_i    (clear && (state_q == CONFIRM)),
        .block_i    (block_in),
        .confirm_o  (confirm),
        .ts_first_o (ts_first)
    );

    assign accept   = (state_q == REPORT) && rpt_ready;
    assign info_pad = (NInfo * RPT_W)'(info_snap_q);
    assign info_idx = beat_q - BeatW'(2);

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        deadlock_d = deadlock_q;
        unique case (state_q)
            IDLE: begin
                if (confirm) begin
                    state_d    = REPORT;
                    deadlock_d = 1'b1;
                end else if (block_in) begin
                    state_d = CONFIRM;
                end
            end
            CONFIRM: begin
                if (clear || !block_in) begin
                    state_d = IDLE;
                end else if (confirm) begin
                    state_d    = REPORT;
                    deadlock_d = 1'b1;
                end
            end
            REPORT: begin
                // clear is deliberately ignored here so a report is never truncated
                if (rpt_ready) begin
                    if (beat_q == LastBeat) begin
                        state_d = HOLD;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (clear) begin
                    state_d    = IDLE;
                    deadlock_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            deadlock_q  <= 1'b0;
            info_snap_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            deadlock_q <= deadlock_d;
            if (confirm) begin
                info_snap_q <= axis_block_info;
            end
        end
    end

`ifdef UDP_DEADLOCK_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, stall_snap_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clear) begin
            stall_cnt_d = '0;
        end else if (block_in && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Snapshot on the handshake that advances onto the stall beat, so it is frozen while shown
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            stall_snap_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (accept && (beat_q == LastBeat - 1'b1)) begin
                stall_snap_q <= stall_cnt_d;
            end
        end
    end
`endif

    always_comb begin
        rpt_data = '0;
        if (state_q == REPORT) begin
            if (beat_q == BeatW'(0)) begin
                rpt_data = {RPT_MAGIC, 8'(NUM_AXIS), 8'(NBeats)};
            end else if (beat_q == BeatW'(1)) begin
                rpt_data = RPT_W'(ts_first);
`ifdef UDP_DEADLOCK_STALL_CNT_EN
            end else if (beat_q == LastBeat) begin
                rpt_data = stall_snap_q;
`endif
            end else begin
                rpt_data = info_pad[info_idx*RPT_W +: RPT_W];
            end
        end
    end

    assign rpt_valid = (state_q == REPORT);
    assign rpt_last  = (state_q == REPORT) && (beat_q == LastBeat);
    assign deadlock  = deadlock_q;

endmodule

// File: tb/tb_udp_hls_deadlock_reporter.sv
// Randomised self-checking bench for udp_hls_deadlock_reporter with a spec-level report model.
// Honours UDP_DEADLOCK_STALL_CNT_EN when the DUT is built with it.
module tb_udp_hls_deadlock_reporter;

    localparam int NA = 4;
    localparam int CC = 16;
    localparam int NINFO_M = (4 * NA + 31) / 32;
`ifdef UDP_DEADLOCK_STALL_CNT_EN
    localparam int NB = 3 + NINFO_M;
`else
    localparam int NB = 2 + NINFO_M;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            block_in = 1'b0;
    logic            clear = 1'b0;
    logic            rpt_ready = 1'b0;
    logic [4*NA-1:0] axis_block_info = '0;
    logic            rpt_valid, rpt_last, deadlock;
    logic [31:0]     rpt_data;

    int checks = 0;
    int failures = 0;

    // Reference state: timestamp, stall count, accepted beats, stability violations
    int          tb_ts = 0;
    int          stall_model = 0;
    int          stall_exp = 0;
    bit          stall_taken = 1'b0;
    int          mon_idx = 0;
    int          hold_viol = 0;
    logic [31:0] acc_data[$];
    logic        acc_last[$];
    logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_reset = 1'b1;
    logic [31:0] p_data = '0;

    udp_hls_deadlock_reporter #(
        .NUM_AXIS       (NA),
        .CONFIRM_CYCLES (CC),
        .TS_WIDTH       (32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .block_in        (block_in),
        .axis_block_info (axis_block_info),
        .clear           (clear),
        .rpt_valid       (rpt_valid),
        .rpt_ready       (rpt_ready),
        .rpt_data        (rpt_data),
        .rpt_last        (rpt_last),
        .deadlock        (deadlock)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        tb_ts <= reset ? 0 : tb_ts + 1;
        if (!reset && !p_reset && p_valid && !p_ready &&
            !(rpt_valid && rpt_data == p_data && rpt_last == p_last)) begin
            hold_viol <= hold_viol + 1;
        end
        if (reset) begin
            mon_idx     <= 0;
            stall_taken <= 1'b0;
            stall_model <= 0;
        end else begin
            if (rpt_valid && mon_idx == NB - 1 && !stall_taken) begin
                stall_exp   <= stall_model;
                stall_taken <= 1'b1;
            end
            if (rpt_valid && rpt_ready) begin
                acc_data.push_back(rpt_data);
                acc_last.push_back(rpt_last);
                mon_idx <= rpt_last ? 0 : mon_idx + 1;
                if (rpt_last) stall_taken <= 1'b0;
            end
            stall_model <= clear ? 0 : (block_in ? stall_model + 1 : stall_model);
        end
        p_valid <= rpt_valid;
        p_ready <= rpt_ready;
        p_data  <= rpt_data;
        p_last  <= rpt_last;
        p_reset <= reset;
    end

    function automatic logic [31:0] exp_beat(int i, int rise, logic [15:0] info);
        logic [31:0] hdr;
        hdr = {16'hDEAD, 8'(NA), 8'(NB)};
        case (i)
            0:       return hdr;
            1:       return 32'(rise);
            2:       return {16'h0000, info};
            default: return 32'(stall_exp);
        endcase
    endfunction

    // Raises block_in, then collects beats until rpt_last is accepted (bounded).
    task automatic drive_report(input logic [15:0] info, input bit rand_ready, input bit pulse_clear,
                                output int rise_ts, output int lat, output bit done);
        bit pulsed;
        pulsed = 1'b0;
        @(negedge clock);
        clear = 1'b0;
        acc_data.delete();
        acc_last.delete();
        block_in = 1'b1;
        axis_block_info = info;
        rise_ts = tb_ts;
        lat = -1;
        done = 1'b0;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(negedge clock);
            clear = 1'b0;
            rpt_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (lat < 0 && rpt_valid) lat = k;
            if (pulse_clear && rpt_valid && !pulsed) begin
                clear = 1'b1;
                pulsed = 1'b1;
            end
            if (acc_last.size() > 0 && acc_last[$]) done = 1'b1;
        end
        rpt_ready = 1'b0;
        clear = 1'b0;
    endtask

    task automatic release_and_clear();
        @(negedge clock);
        block_in = 1'b0;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (rpt_valid !== 1'b0 || rpt_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid_last got=%b/%b exp=0/0", rpt_valid, rpt_last);
        end
        checks++;
        if (rpt_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00000000", rpt_data);
        end
        checks++;
        if (deadlock !== 1'b0) begin
            failures++;
            $display("FAIL reset_deadlock got=%b exp=0", deadlock);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_glitch();
        int len;
        bit bad;
        for (int t = 0; t < 4; t++) begin
            len = (t == 0) ? 10 : int'($urandom_range(1, CC - 1));
            bad = 1'b0;
            for (int c = 0; c < len + 5; c++) begin
                @(negedge clock);
                if (rpt_valid !== 1'b0 || deadlock !== 1'b0) bad = 1'b1;
                block_in = (c < len);
                axis_block_info = 16'($urandom);
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL glitch_len%0d saw valid/deadlock=%b/%b exp=0/0", len, rpt_valid,
                         deadlock);
            end
        end
    endtask

    task automatic test_report_basic();
        int rise, lat;
        bit done;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int w = 0; w < 200 && tb_ts != 99; w++) @(negedge clock);
        drive_report(16'hBEDF, 1'b0, 1'b0, rise, lat, done);
        checks++;
        if (!done || rise != 100) begin
            failures++;
            $display("FAIL basic_done got=%b rise=%0d exp=1 rise=100", done, rise);
        end
        checks++;
        if (lat != CC + 1) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=%0d", lat, CC + 1);
        end
        checks++;
        if (acc_data.size() != NB) begin
            failures++;
            $display("FAIL basic_nbeats got=%0d exp=%0d", acc_data.size(), NB);
        end
        for (int i = 0; i < acc_data.size(); i++) begin
            checks++;
            if (acc_data[i] !== exp_beat(i, rise, 16'hBEDF) || acc_last[i] !== (i == NB - 1)) begin
                failures++;
                $display("FAIL basic_beat%0d got=%h/%b exp=%h/%b", i, acc_data[i], acc_last[i],
                         exp_beat(i, rise, 16'hBEDF), (i == NB - 1));
            end
        end
        @(negedge clock);
        checks++;
        if (deadlock !== 1'b1 || rpt_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold got dl/valid=%b/%b exp=1/0", deadlock, rpt_valid);
        end
        release_and_clear();
        checks++;
        if (deadlock !== 1'b0) begin
            failures++;
            $display("FAIL basic_clear got=%b exp=0", deadlock);
        end
    endtask

    task automatic test_random_ready();
        int rise, lat, viol0;
        bit done;
        logic [15:0] info;
        for (int t = 0; t < 4; t++) begin
            repeat ($urandom_range(1, 7)) @(negedge clock);
            info = 16'($urandom);
            viol0 = hold_viol;
            drive_report(info, 1'b1, 1'b0, rise, lat, done);
            checks++;
            if (!done || lat != CC + 1 || acc_data.size() != NB) begin
                failures++;
                $display("FAIL rr%0d_shape done=%b lat=%0d beats=%0d exp=1/%0d/%0d", t, done, lat,
                         acc_data.size(), CC + 1, NB);
            end
            for (int i = 0; i < acc_data.size(); i++) begin
                checks++;
                if (acc_data[i] !== exp_beat(i, rise, info) || acc_last[i] !== (i == NB - 1)) begin
                    failures++;
                    $display("FAIL rr%0d_beat%0d got=%h/%b exp=%h/%b", t, i, acc_data[i],
                             acc_last[i], exp_beat(i, rise, info), (i == NB - 1));
                end
            end
            checks++;
            if (hold_viol != viol0) begin
                failures++;
                $display("FAIL rr%0d_stable got=%0d unstable beats exp=0", t, hold_viol - viol0);
            end
            release_and_clear();
        end
    endtask

    task automatic test_clear();
        int rise, lat, rise2;
        bit done;
        logic [15:0] info;
        // clear during CONFIRM restarts the filter from the following cycle
        @(negedge clock);
        block_in = 1'b1;
        repeat (7) @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        info = 16'($urandom);
        drive_report(info, 1'b0, 1'b0, rise, lat, done);
        checks++;
        if (!done || lat != CC + 1 || acc_data.size() < 2 || acc_data[1] !== 32'(rise)) begin
            failures++;
            $display("FAIL abort_restart done=%b lat=%0d ts=%h exp=1/%0d/%h", done, lat,
                     (acc_data.size() > 1) ? acc_data[1] : 32'hx, CC + 1, rise);
        end
        release_and_clear();
        // clear during REPORT never truncates
        info = 16'($urandom);
        drive_report(info, 1'b1, 1'b1, rise, lat, done);
        checks++;
        if (!done || acc_data.size() != NB) begin
            failures++;
            $display("FAIL clr_report_beats got=%0d done=%b exp=%0d", acc_data.size(), done, NB);
        end
        for (int i = 0; i < acc_data.size(); i++) begin
            checks++;
            if (acc_data[i] !== exp_beat(i, rise, info) || acc_last[i] !== (i == NB - 1)) begin
                failures++;
                $display("FAIL clr_beat%0d got=%h/%b exp=%h/%b", i, acc_data[i], acc_last[i],
                         exp_beat(i, rise, info), (i == NB - 1));
            end
        end
        @(negedge clock);
        checks++;
        if (deadlock !== 1'b1) begin
            failures++;
            $display("FAIL clr_hold_deadlock got=%b exp=1", deadlock);
        end
        // clear in HOLD with block still high: IDLE, then a fresh confirm
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checks++;
        if (deadlock !== 1'b0) begin
            failures++;
            $display("FAIL clr_hold_release got=%b exp=0", deadlock);
        end
        rise2 = tb_ts;
        info = 16'($urandom);
        drive_report(info, 1'b0, 1'b0, rise, lat, done);
        checks++;
        if (!done || lat != CC || acc_data.size() != NB || acc_data[1] !== 32'(rise2)) begin
            failures++;
            $display("FAIL clr_rearm done=%b lat=%0d beats=%0d exp=1/%0d/%0d ts=%h", done, lat,
                     acc_data.size(), CC, NB, rise2);
        end
        release_and_clear();
    endtask

    task automatic test_reset_mid();
        int rise, lat;
        bit done;
        logic [15:0] info;
        @(negedge clock);
        acc_data.delete();
        acc_last.delete();
        block_in = 1'b1;
        rpt_ready = 1'b1;
        for (int k = 0; k < 100 && acc_data.size() < 1; k++) @(negedge clock);
        checks++;
        if (acc_data.size() != 1 || rpt_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_beat1 beats=%0d valid=%b exp=1/1", acc_data.size(), rpt_valid);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (rpt_valid !== 1'b0 || deadlock !== 1'b0) begin
            failures++;
            $display("FAIL rmid_drop valid/dl=%b/%b exp=0/0", rpt_valid, deadlock);
        end
        reset = 1'b0;
        block_in = 1'b0;
        rpt_ready = 1'b0;
        repeat (3) @(negedge clock);
        info = 16'($urandom);
        drive_report(info, 1'b1, 1'b0, rise, lat, done);
        checks++;
        if (!done || acc_data.size() != NB) begin
            failures++;
            $display("FAIL rmid_fresh done=%b beats=%0d exp=1/%0d", done, acc_data.size(), NB);
        end
        for (int i = 0; i < acc_data.size(); i++) begin
            checks++;
            if (acc_data[i] !== exp_beat(i, rise, info) || acc_last[i] !== (i == NB - 1)) begin
                failures++;
                $display("FAIL rmid_beat%0d got=%h/%b exp=%h/%b", i, acc_data[i], acc_last[i],
                         exp_beat(i, rise, info), (i == NB - 1));
            end
        end
        release_and_clear();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_report_basic();
        test_random_ready();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
